nfu2_accum_ctrl: RTL

Sequencer for the NFU-2 adder-tree stage. It accepts Tn-wide product beats from NFU-1 and counts the input steps of each output tile. It drives the NFU-2 partial-sum input, using zero on the first step of a tile and the running accumulator otherwise. Completed tile sums go into a 2-entry output buffer that feeds NFU-3 over a valid/ready handshake. It sits between NFU-1 and NFU-3 and stalls NFU-1 so that no completed tile sum is lost, because the NFU-2 pipeline has no enable.

---
 rtl/nfu2_accum_ctrl_if.sv | 32 +++
 rtl/nfu2_accum_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/nfu2_accum_ctrl_if.sv
// nfu2_accum_ctrl_if
//   Datapath and handshake bundle around the NFU-2 accumulation controller.
//   master : controller side (accepts NFU-1 beats, drives the NFU-2 partial sum,
//            presents completed tile sums to NFU-3)
//   slave  : environment side (NFU-1 valid, NFU-2 result, NFU-3 ready)
//   Signals:
//     i_nfu1_valid / o_nfu1_ready : NFU-1 beat handshake
//     o_nfu2_nbout                : partial-sum input to NFU-2 (stage 2)
//     i_nfu2_out                  : NFU-2 result (stage 2)
//     o_out_valid / o_out_data / i_out_ready : output buffer to NFU-3
interface nfu2_accum_ctrl_if #(
    parameter int unsigned N  = 16,
    parameter int unsigned Tn = 16
);
    logic            i_nfu1_valid;
    logic            o_nfu1_ready;
    logic [N*Tn-1:0] o_nfu2_nbout;
    logic [N*Tn-1:0] i_nfu2_out;
    logic            o_out_valid;
    logic [N*Tn-1:0] o_out_data;
    logic            i_out_ready;

    modport master (
        input  i_nfu1_valid, i_nfu2_out, i_out_ready,
        output o_nfu1_ready, o_nfu2_nbout, o_out_valid, o_out_data
    );

    modport slave (
        output i_nfu1_valid, i_nfu2_out, i_out_ready,
        input  o_nfu1_ready, o_nfu2_nbout, o_out_valid, o_out_data
    );
endinterface

// File: rtl/nfu2_accum_ctrl.sv
// nfu2_accum_ctrl
//   Sequencer for the NFU-2 adder-tree stage. Counts input steps per output
//   tile, selects zero or the running accumulator as the NFU-2 partial sum,
//   and buffers completed tile sums in a 2-entry FIFO toward NFU-3.
//   Ports:
//     clk, rst_n               : clock, async active-low reset
//     i_start                  : job start pulse (honoured only in IDLE)
//     i_num_steps, i_num_tiles : job configuration, latched at start
//     o_busy, o_done           : job status
//     bus (master)             : NFU-1 / NFU-2 / NFU-3 datapath and handshakes
module nfu2_accum_ctrl #(
    parameter int unsigned N  = 16,
    parameter int unsigned Tn = 16,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic [CW-1:0] i_num_steps,
    input  logic [CW-1:0] i_num_tiles,
    output logic          o_busy,
    output logic          o_done,
    nfu2_accum_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   num_steps_q, num_tiles_q;
    logic [CW-1:0]   step_cnt, tile_cnt;
    logic            s2_valid, s2_first, s2_last;
    logic [N*Tn-1:0] acc;
    logic [N*Tn-1:0] fifo_head, fifo_tail;
    logic [1:0]      fifo_count;
    logic            accept, is_last_step, is_last_tile, credit_ok;
    logic            push, pop;

    assign is_last_step = (step_cnt == num_steps_q - CW'(1));
    assign is_last_tile = (tile_cnt == num_tiles_q - CW'(1));
    // A last-step beat reserves a FIFO slot: count the entry still in flight
    // in stage 2 so a completed sum can never arrive at a full buffer.
    assign credit_ok    = ({1'b0, fifo_count} + {2'b00, s2_valid && s2_last}) < 3'd2;
    assign accept       = bus.i_nfu1_valid && bus.o_nfu1_ready;
    assign push         = s2_valid && s2_last;
    assign pop          = bus.o_out_valid && bus.i_out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (i_start)
                       state_next = (i_num_steps == '0 || i_num_tiles == '0) ? DONE : RUN;
            RUN:   if (accept && is_last_step && is_last_tile) state_next = DRAIN;
            DRAIN: if (!s2_valid && fifo_count == 2'd0) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_busy           = 1'b0;
        o_done           = 1'b0;
        bus.o_nfu1_ready = 1'b0;
        case (state)
            RUN: begin
                o_busy           = 1'b1;
                bus.o_nfu1_ready = !is_last_step || credit_ok;
            end
            DRAIN: o_busy = 1'b1;
            DONE: begin
                o_busy = 1'b1;
                o_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Configuration and step/tile counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_steps_q <= '0;
            num_tiles_q <= '0;
            step_cnt    <= '0;
            tile_cnt    <= '0;
        end else if (state == IDLE && i_start) begin
            num_steps_q <= i_num_steps;
            num_tiles_q <= i_num_tiles;
            step_cnt    <= '0;
            tile_cnt    <= '0;
        end else if (accept) begin
            if (is_last_step) begin
                step_cnt <= '0;
                tile_cnt <= tile_cnt + CW'(1);
            end else begin
                step_cnt <= step_cnt + CW'(1);
            end
        end
    end

    // Stage-2 tags track the beat currently inside NFU-2; acc follows stage 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            acc      <= '0;
        end else begin
            s2_valid <= accept;
            s2_first <= (step_cnt == '0);
            s2_last  <= is_last_step;
            if (s2_valid) acc <= bus.i_nfu2_out;
        end
    end

    assign bus.o_nfu2_nbout = (s2_valid && s2_first) ? '0 : acc;

    // 2-entry output FIFO with registered head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_head  <= '0;
            fifo_tail  <= '0;
            fifo_count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (fifo_count == 2'd0) fifo_head <= bus.i_nfu2_out;
                    else                    fifo_tail <= bus.i_nfu2_out;
                    if (fifo_count != 2'd2) fifo_count <= fifo_count + 2'd1;
                end
                2'b01: begin
                    fifo_head  <= fifo_tail;
                    fifo_count <= fifo_count - 2'd1;
                end
                2'b11: begin
                    if (fifo_count == 2'd1) begin
                        fifo_head <= bus.i_nfu2_out;
                    end else begin
                        fifo_head <= fifo_tail;
                        fifo_tail <= bus.i_nfu2_out;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_out_valid = (fifo_count != 2'd0);
    assign bus.o_out_data  = fifo_head;
endmodule
